// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the control_unit sequencer: FSM states,
// opcodes, ALU function codes, bus-source selects and IR field positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_3REG, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_ROR  = 4'b0101;
    localparam logic [3:0] ALU_ROL  = 4'b0110;
    localparam logic [3:0] ALU_SHL  = 4'b0111;
    localparam logic [3:0] ALU_SHR  = 4'b1000;
    localparam logic [3:0] ALU_SHRA = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_NEG  = 4'b1100;
    localparam logic [3:0] ALU_NOT  = 4'b1101;

    localparam logic [4:0] BUS_ZHIGH = 5'b10010;
    localparam logic [4:0] BUS_ZLOW  = 5'b10011;
    localparam logic [4:0] BUS_PC    = 5'b10100;
    localparam logic [4:0] BUS_MDR   = 5'b10101;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_LSB  = 15;

    // General-purpose registers occupy the lower half of the bus-select space.
    function automatic logic [4:0] gp_bus(input logic [3:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control and status bundle between the sequencer (master) and the datapath
// side (slave); clock and reset are carried separately.
interface control_unit_if;
    logic        start;
    logic        mem_ready;
    logic [31:0] IR_q;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr;
    logic [3:0]  ALU_op;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic        incPC, MDR_read;
    logic        run;
    logic        illegal;

    modport master (
        input  start, mem_ready, IR_q,
        output BusDataSelect, GP_addr, ALU_op,
        output e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
        output incPC, MDR_read, run, illegal
    );

    modport slave (
        output start, mem_ready, IR_q,
        input  BusDataSelect, GP_addr, ALU_op,
        input  e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
        input  incPC, MDR_read, run, illegal
    );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode decode: ALU function code and instruction class.
module opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic [3:0] alu_op_o,
    output op_class_t  class_o
);

    always_comb begin
        alu_op_o = ALU_PASS;
        class_o  = CLS_ILLEGAL;
        case (opcode_i)
            OP_ADD:  begin alu_op_o = ALU_ADD;  class_o = CLS_3REG;   end
            OP_SUB:  begin alu_op_o = ALU_SUB;  class_o = CLS_3REG;   end
            OP_AND:  begin alu_op_o = ALU_AND;  class_o = CLS_3REG;   end
            OP_OR:   begin alu_op_o = ALU_OR;   class_o = CLS_3REG;   end
            OP_ROR:  begin alu_op_o = ALU_ROR;  class_o = CLS_3REG;   end
            OP_ROL:  begin alu_op_o = ALU_ROL;  class_o = CLS_3REG;   end
            OP_SHR:  begin alu_op_o = ALU_SHR;  class_o = CLS_3REG;   end
            OP_SHRA: begin alu_op_o = ALU_SHRA; class_o = CLS_3REG;   end
            OP_SHL:  begin alu_op_o = ALU_SHL;  class_o = CLS_3REG;   end
            OP_DIV:  begin alu_op_o = ALU_DIV;  class_o = CLS_MULDIV; end
            OP_MUL:  begin alu_op_o = ALU_MUL;  class_o = CLS_MULDIV; end
            OP_NEG:  begin alu_op_o = ALU_NEG;  class_o = CLS_UNARY;  end
            OP_NOT:  begin alu_op_o = ALU_NOT;  class_o = CLS_UNARY;  end
            OP_NOP:  class_o = CLS_NOP;
            OP_HALT: class_o = CLS_HALT;
            default: class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer driving the datapath: fetch over the shared bus, then fixed
// T-state execution of register ALU, unary, mul/div, nop and halt instructions.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master cu
);

    state_t    state_q, state_d;
    logic      illegal_q, illegal_d;
    logic      mem_rdy;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic [3:0] dec_alu_op;
    op_class_t  dec_class;
    logic       unused_ir;

    assign mem_rdy   = MEM_WAIT_EN ? cu.mem_ready : 1'b1;
    assign opcode    = cu.IR_q[OPC_LSB +: 5];
    assign ra        = cu.IR_q[RA_LSB +: 4];
    assign rb        = cu.IR_q[RB_LSB +: 4];
    assign rc        = cu.IR_q[RC_LSB +: 4];
    assign unused_ir = ^cu.IR_q[RC_LSB-1:0];

    opcode_decode u_decode (
        .opcode_i (opcode),
        .alu_op_o (dec_alu_op),
        .class_o  (dec_class)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        illegal_d        = illegal_q;
        cu.BusDataSelect = '0;
        cu.GP_addr       = '0;
        cu.ALU_op        = ALU_PASS;
        cu.e_PC          = 1'b0;
        cu.e_IR          = 1'b0;
        cu.e_Y           = 1'b0;
        cu.e_Z           = 1'b0;
        cu.e_HI          = 1'b0;
        cu.e_LO          = 1'b0;
        cu.e_MDR         = 1'b0;
        cu.e_MAR         = 1'b0;
        cu.e_GP          = 1'b0;
        cu.incPC         = 1'b0;
        cu.MDR_read      = 1'b0;
        cu.run           = (state_q != S_IDLE) && (state_q != S_HALT);
        cu.illegal       = illegal_q;

        case (state_q)
            S_IDLE: if (cu.start) state_d = S_T0;
            S_T0: begin
                cu.BusDataSelect = BUS_PC;
                cu.e_MAR         = 1'b1;
                cu.incPC         = 1'b1;
                cu.e_Z           = 1'b1;
                state_d          = S_T1;
            end
            S_T1: begin
                // PC and MDR capture only on the cycle memory data is valid.
                cu.BusDataSelect = BUS_ZLOW;
                cu.MDR_read      = 1'b1;
                cu.e_PC          = mem_rdy;
                cu.e_MDR         = mem_rdy;
                if (mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                cu.BusDataSelect = BUS_MDR;
                cu.e_IR          = 1'b1;
                state_d          = S_T3;
            end
            S_T3: begin
                case (dec_class)
                    CLS_3REG, CLS_UNARY: begin
                        cu.BusDataSelect = gp_bus(rb);
                        cu.e_Y           = 1'b1;
                        state_d          = S_T4;
                    end
                    CLS_MULDIV: begin
                        cu.BusDataSelect = gp_bus(ra);
                        cu.e_Y           = 1'b1;
                        state_d          = S_T4;
                    end
                    CLS_HALT: state_d = S_HALT;
                    CLS_ILLEGAL: begin
                        illegal_d  = 1'b1;
                        cu.illegal = 1'b1;
                        state_d    = S_T0;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                cu.BusDataSelect = (dec_class == CLS_3REG) ? gp_bus(rc) : gp_bus(rb);
                cu.ALU_op        = dec_alu_op;
                cu.e_Z           = 1'b1;
                state_d          = S_T5;
            end
            S_T5: begin
                cu.BusDataSelect = BUS_ZLOW;
                if (dec_class == CLS_MULDIV) begin
                    cu.e_LO = 1'b1;
                    state_d = S_T6;
                end else begin
                    cu.GP_addr = ra;
                    cu.e_GP    = 1'b1;
                    state_d    = S_T0;
                end
            end
            S_T6: begin
                cu.BusDataSelect = BUS_ZHIGH;
                cu.e_HI          = 1'b1;
                state_d          = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected cycle
// sequences are built from the instruction-level rules and compared each cycle.
module tb_control_unit;

    logic clk = 1'b0;
    logic clr;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] mdatain  = '0;
    logic [31:0] ir_reg   = '0;
    bit          ill_model = 1'b0;
    logic [31:0] exp_q[$];
    bit          rdy_q[$];

    localparam logic [10:0] M_PC  = 11'h400, M_IR  = 11'h200, M_Y   = 11'h100,
                            M_Z   = 11'h080, M_HI  = 11'h040, M_LO  = 11'h020,
                            M_MDR = 11'h010, M_MAR = 11'h008, M_GP  = 11'h004,
                            M_INC = 11'h002, M_RD  = 11'h001;

    control_unit_if cu_if();

    control_unit #(.MEM_WAIT_EN(1'b1)) u_dut (
        .clock (clk),
        .clear (clr),
        .cu    (cu_if)
    );

    always #5 clk = ~clk;

    // Minimal datapath stand-in: IR loads from memory data when enabled.
    always @(posedge clk) if (cu_if.e_IR) ir_reg <= mdatain;
    assign cu_if.IR_q = ir_reg;

    function automatic logic [31:0] pack(input bit run, input bit ill, input logic [4:0] bus,
                                         input logic [3:0] gp, input logic [3:0] alu,
                                         input logic [10:0] en);
        return {6'b0, run, ill, bus, gp, alu, en};
    endfunction

    function automatic logic [31:0] observed();
        return {6'b0, cu_if.run, cu_if.illegal, cu_if.BusDataSelect, cu_if.GP_addr, cu_if.ALU_op,
                cu_if.e_PC, cu_if.e_IR, cu_if.e_Y, cu_if.e_Z, cu_if.e_HI, cu_if.e_LO,
                cu_if.e_MDR, cu_if.e_MAR, cu_if.e_GP, cu_if.incPC, cu_if.MDR_read};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 three-register, 1 unary, 2 mul/div, 3 nop, 4 halt, 5 illegal
    task automatic classify(input logic [4:0] op, output int kind, output logic [3:0] alu);
        alu = 4'd0;
        case (op)
            5'd3:  begin kind = 0; alu = 4'd1;  end
            5'd4:  begin kind = 0; alu = 4'd2;  end
            5'd5:  begin kind = 0; alu = 4'd3;  end
            5'd6:  begin kind = 0; alu = 4'd4;  end
            5'd7:  begin kind = 0; alu = 4'd5;  end
            5'd8:  begin kind = 0; alu = 4'd6;  end
            5'd9:  begin kind = 0; alu = 4'd8;  end
            5'd10: begin kind = 0; alu = 4'd9;  end
            5'd11: begin kind = 0; alu = 4'd7;  end
            5'd15: begin kind = 2; alu = 4'd11; end
            5'd16: begin kind = 2; alu = 4'd10; end
            5'd17: begin kind = 1; alu = 4'd12; end
            5'd18: begin kind = 1; alu = 4'd13; end
            5'd26: kind = 3;
            5'd27: kind = 4;
            default: kind = 5;
        endcase
    endtask

    task automatic build(input logic [31:0] instr, input int stalls);
        int kind;
        logic [3:0] alu, ra, rb, rc;
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        classify(instr[31:27], kind, alu);
        exp_q.push_back(pack(1, ill_model, 5'b10100, 0, 0, M_MAR | M_INC | M_Z)); rdy_q.push_back(1);
        for (int s = 0; s < stalls; s++) begin
            exp_q.push_back(pack(1, ill_model, 5'b10011, 0, 0, M_RD)); rdy_q.push_back(0);
        end
        exp_q.push_back(pack(1, ill_model, 5'b10011, 0, 0, M_RD | M_PC | M_MDR)); rdy_q.push_back(1);
        exp_q.push_back(pack(1, ill_model, 5'b10101, 0, 0, M_IR)); rdy_q.push_back(1);
        if (kind <= 2) begin
            exp_q.push_back(pack(1, ill_model, {1'b0, (kind == 2) ? ra : rb}, 0, 0, M_Y));
            rdy_q.push_back(1);
            exp_q.push_back(pack(1, ill_model, {1'b0, (kind == 0) ? rc : rb}, 0, alu, M_Z));
            rdy_q.push_back(1);
            if (kind == 2) begin
                exp_q.push_back(pack(1, ill_model, 5'b10011, 0, 0, M_LO)); rdy_q.push_back(1);
                exp_q.push_back(pack(1, ill_model, 5'b10010, 0, 0, M_HI)); rdy_q.push_back(1);
            end else begin
                exp_q.push_back(pack(1, ill_model, 5'b10011, ra, 0, M_GP)); rdy_q.push_back(1);
            end
        end else begin
            if (kind == 5) ill_model = 1'b1;
            exp_q.push_back(pack(1, ill_model, 0, 0, 0, 0)); rdy_q.push_back(1);
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] instr, input int stalls);
        int k;
        exp_q.delete();
        rdy_q.delete();
        mdatain = instr;
        build(instr, stalls);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cu_if.mem_ready = rdy_q.pop_front();
            cu_if.start     = 1'($urandom);
            #1 check($sformatf("%s c%0d", name, k), observed(), exp_q.pop_front());
            k++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cu_if.start     = 1'b1;
        cu_if.mem_ready = 1'b1;
        @(posedge clk);
        #1 cu_if.start = 1'b0;
    endtask

    task automatic idle_checks(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 check($sformatf("%s %0d", name, i), observed(), pack(0, ill_model, 0, 0, 0, 0));
        end
    endtask

    localparam int N_LEGAL = 14;
    localparam int N_ILL   = 17;
    logic [4:0] legal_ops [N_LEGAL] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                        5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
    logic [4:0] ill_ops [N_ILL] = '{5'd0, 5'd1, 5'd2, 5'd12, 5'd13, 5'd14, 5'd19, 5'd20, 5'd21,
                                    5'd22, 5'd23, 5'd24, 5'd25, 5'd28, 5'd29, 5'd30, 5'd31};

    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        clr             = 1'b1;
        cu_if.start     = 1'b0;
        cu_if.mem_ready = 1'b0;
        #1 check("reset", observed(), pack(0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1 check("reset_hold", observed(), pack(0, 0, 0, 0, 0, 0));
        clr = 1'b0;
        idle_checks("idle", 3);

        pulse_start();
        run_instr("shl", 32'h5A1B8000, 0);
        run_instr("add_stall", 32'h18928000, 3);
        run_instr("mul", 32'h83380000, 0);
        run_instr("nop", 32'hD0000000, 0);
        run_instr("illegal", 32'hF8000000, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = ill_ops[$urandom_range(0, N_ILL - 1)];
            else                           op = legal_ops[$urandom_range(0, N_LEGAL - 1)];
            instr = {op, 27'($urandom)};
            run_instr($sformatf("rnd%0d", i), instr, int'($urandom_range(0, 3)));
        end

        // Abort an add during T4 with an asynchronous clear.
        exp_q.delete();
        rdy_q.delete();
        mdatain = 32'h18928000;
        build(mdatain, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cu_if.mem_ready = rdy_q.pop_front();
            cu_if.start     = 1'b0;
            #1 check($sformatf("abort c%0d", k), observed(), exp_q.pop_front());
        end
        #1 clr = 1'b1;
        ill_model = 1'b0;
        #1 check("clear_async", observed(), pack(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 clr = 1'b0;
        idle_checks("post_clear", 4);

        pulse_start();
        run_instr("nop2", 32'hD0000000, 0);
        run_instr("halt", 32'hD8000000, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cu_if.start = 1'($urandom);
            #1 check($sformatf("halted %0d", i), observed(), pack(0, ill_model, 0, 0, 0, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencer that drives every control input of the `datapath` block. It fetches instructions over the shared bus and executes the register-format ALU, multiply/divide, nop and halt instructions in fixed T-states. It replaces hand-driven state sequencing and sits between `datapath` and the top-level CPU wrapper.

## Interface
Parameters:
- `MEM_WAIT_EN`, default 1: 1 = T1 stalls until `mem_ready`; 0 = `mem_ready` is ignored and treated as 1.

Ports:
- `clock` in 1: single system clock, rising edge.
- `clear` in 1: reset, asynchronous, active-high.
- `start` in 1: leaves IDLE, sampled only in IDLE.
- `mem_ready` in 1: memory read data valid on `Mdatain`.
- `IR_q` in 32: current IR contents from datapath.
- `BusDataSelect` out 5: bus source select.
- `GP_addr` out 4: GP register write address.
- `ALU_op` out 4: ALU function.
- `e_PC`, `e_IR`, `e_Y`, `e_Z`, `e_HI`, `e_LO`, `e_MDR`, `e_MAR`, `e_GP`, `incPC`, `MDR_read` out 1 each: datapath load enables and controls.
- `run` out 1: high in every state except IDLE and HALT.
- `illegal` out 1: sticky flag for an unsupported opcode; cleared only by `clear`.

## Operation
- Instruction fields: opcode `IR_q[31:27]`, ra `[26:23]`, rb `[22:19]`, rc `[18:15]`.
- Bus codes: 0_rrrr = GP register rrrr, 10000 = HI, 10001 = LO, 10010 = Zhigh, 10011 = Zlow, 10100 = PC, 10101 = MDR.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, div 01111, mul 10000, neg 10001, not 10010, nop 11010, halt 11011. All others are illegal.
- ALU_op values: pass 0000, add 0001, sub 0010, and 0011, or 0100, ror 0101, rol 0110, shl 0111, shr 1000, shra 1001, mul 1010, div 1011, neg 1100, not 1101.
- States and transitions: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
  - IDLE -start-> T0.
  - T0 → T1 → T2 → T3. T1 self-loops while `mem_ready`=0.
  - T3: nop or illegal → T0; halt → HALT; otherwise → T4.
  - T4 → T5.
  - T5: mul/div → T6; otherwise → T0.
  - T6 → T0. HALT holds until `clear`.
- Per-state outputs. Any signal not listed is 0, and GP_addr/ALU_op read 0.
  - T0: bus PC, e_MAR, incPC, e_Z, ALU_op pass.
  - T1: bus Zlow, MDR_read. e_PC and e_MDR are asserted only while `mem_ready`=1.
  - T2: bus MDR, e_IR.
  - T3 (ALU/mul/div): bus R[rb] for 3-register ops, bus R[ra] for mul/div, neg/not bus R[rb]; e_Y. For nop/halt/illegal, all outputs are 0.
  - T4: bus R[rc] for 3-register ops, R[rb] for mul/div/neg/not; ALU_op per opcode; e_Z.
  - T5: bus Zlow. Non-mul/div: GP_addr = ra, e_GP. mul/div: e_LO.
  - T6: bus Zhigh, e_HI.
- `illegal` sets on the T3 cycle whose opcode is illegal.

## Timing
- Outputs are a pure decode of the registered state and `IR_q`. No output depends combinationally on `start`. `mem_ready` gates e_PC/e_MDR only in T1.
- The datapath captures on the rising edge that ends each state. IR is valid from T3 onward.
- Instruction latency from T0 entry to the next T0 entry, with no stall:
  - nop: 4 cycles.
  - ALU, neg, not: 6 cycles.
  - mul, div: 7 cycles.
  - Each T1 wait cycle adds 1.
- Reset: state IDLE, all outputs 0 (BusDataSelect 00000, GP_addr 0000, ALU_op 0000), `run` 0, `illegal` 0.
- Asserting `clear` mid-instruction aborts immediately, with no partial writeback after release.
- `start` high in any other state is ignored.

## Structure
- Package `cpu_ctrl_pkg`: state enum, opcode constants, ALU_op constants, bus-select constants, IR field index constants.
- Sub-module `opcode_decode`: combinational map from opcode to {ALU_op, class (3-register / unary / muldiv / nop / halt / illegal)}.

## Test plan
- After `clear`, pulse `start`, return Mdatain 0x5A1B8000 (shl R4,R3,R7), `mem_ready` high. Expected sequence: T0 bus 10100; T1 bus 10011; T2 bus 10101; T3 bus 00011 e_Y; T4 bus 00111 ALU_op 0111 e_Z; T5 bus 10011 GP_addr 0100 e_GP; then T0.
- 0x18928000 (add R1,R2,R5) with `mem_ready` low for 3 cycles in T1. Expected: T1 lasts 4 cycles, e_PC and e_MDR high only in the last cycle, ALU_op 0001, write to GP_addr 0001.
- 0x83380000 (mul R6,R7). Expected: T3 bus 00110, T4 bus 00111 ALU_op 1010, T5 e_LO bus 10011, T6 e_HI bus 10010, no e_GP.
- 0xD0000000 (nop), then 0xD8000000 (halt). Expected: nop returns to T0 after T3 with no enables; halt leaves `run`=0 and all outputs 0 for 10+ cycles, with `start` ignored.
- Opcode 11111. Expected: `illegal` rises in T3 and stays high, and fetch continues at T0.
- `clear` asserted during T4. Expected: all outputs 0 asynchronously, state IDLE, `illegal` 0.
